// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encoding, default
// vector table layout and the ISR address helper used by CSR/fetch logic.
package interrupt_arbiter_pkg;

    localparam int          NUM_SRC_DEF    = 4;
    localparam int          ID_W_DEF       = 2;
    localparam logic [31:0] VEC_BASE_DEF   = 32'd20;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TAKE   = 2'd1,
        ST_ISR    = 2'd2,
        ST_RETURN = 2'd3
    } arb_state_t;

    // 32-bit unsigned vector address; wrap-around is deliberately ignored.
    function automatic logic [31:0] isr_vector(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [31:0] id);
        return base + id * stride;
    endfunction

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Bundle between the interrupt arbiter (slave) and the fetch/CSR side (master).
// Handshake: the arbiter's request (pending & ~mask & enable) is the valid, take_ready is the ready;
// a redirect transfers only in a cycle where both are high while the arbiter is idle.
interface interrupt_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
);
    import interrupt_arbiter_pkg::*;

    logic [NUM_SRC-1:0] irq_in;
    logic               irq_enable;
    logic               mask_wr_en;
    logic [NUM_SRC-1:0] mask_wr_data;
    logic               take_ready;
    logic               isr_return;
    logic [31:0]        pc_next;
    logic [31:0]        pc_next_final;
    logic               epc_wr_en;
    logic [31:0]        epc_wr_data;
    logic [ID_W-1:0]    cause_id;
    logic               in_isr;
    logic [NUM_SRC-1:0] pending;
    arb_state_t         state;

    modport master (
        output irq_in, irq_enable, mask_wr_en, mask_wr_data, take_ready, isr_return, pc_next,
        input  pc_next_final, epc_wr_en, epc_wr_data, cause_id, in_isr, pending, state
    );

    modport slave (
        input  irq_in, irq_enable, mask_wr_en, mask_wr_data, take_ready, isr_return, pc_next,
        output pc_next_final, epc_wr_en, epc_wr_data, cause_id, in_isr, pending, state
    );

endinterface

// File: rtl/interrupt_arbiter_irq_priority_encoder.sv
// Combinational fixed-priority encoder: lowest set index wins.
module irq_priority_encoder #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req_vec,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    always_comb begin
        valid = |req_vec;
        id    = '0;
        // Walk from the top so the lowest index is the last (winning) assignment.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: edge-detects sources into a pending register, masks and
// prioritises them, and sequences the PC redirect into and back out of an ISR.
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int          NUM_SRC    = NUM_SRC_DEF,
    parameter int          ID_W       = ID_W_DEF,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input logic                clk,
    input logic                reset,
    interrupt_arbiter_if.slave bus
);

    arb_state_t         state;
    arb_state_t         state_nx;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr_vec;
    logic [31:0]        saved_pc;
    logic [ID_W-1:0]    cause_q;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;
    logic               req;
    logic               take_go;
    logic [31:0]        pc_final;
    logic               epc_en;

    assign rise = bus.irq_in & ~irq_prev;
    assign elig = pending & ~mask;
    assign req  = bus.irq_enable & win_valid;

    irq_priority_encoder #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req_vec (elig),
        .valid   (win_valid),
        .id      (win_id)
    );

    always_comb begin
        state_nx = state;
        take_go  = 1'b0;
        clr_vec  = '0;
        pc_final = bus.pc_next;
        epc_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req && bus.take_ready) begin
                    state_nx = ST_TAKE;
                    take_go  = 1'b1;
                end
            end
            ST_TAKE: begin
                // cause_q was loaded at the IDLE->TAKE decision, so it is the held winner.
                pc_final = isr_vector(VEC_BASE, VEC_STRIDE, 32'(cause_q));
                epc_en   = 1'b1;
                clr_vec  = NUM_SRC'(1) << cause_q;
                state_nx = ST_ISR;
            end
            ST_ISR: begin
                if (bus.isr_return) state_nx = ST_RETURN;
            end
            ST_RETURN: begin
                pc_final = saved_pc;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pending  <= '0;
            mask     <= '0;
            irq_prev <= '0;
            saved_pc <= '0;
            cause_q  <= '0;
        end else begin
            state    <= state_nx;
            irq_prev <= bus.irq_in;
            // A fresh edge on the winner in its TAKE cycle keeps the bit set.
            pending  <= (pending & ~clr_vec) | rise;
            if (bus.mask_wr_en) mask <= bus.mask_wr_data;
            if (take_go) cause_q <= win_id;
            if (state == ST_TAKE) saved_pc <= bus.pc_next;
        end
    end

    assign bus.pc_next_final = pc_final;
    assign bus.epc_wr_en     = epc_en;
    assign bus.epc_wr_data   = bus.pc_next;
    assign bus.cause_id      = cause_q;
    assign bus.in_isr        = (state != ST_IDLE);
    assign bus.pending       = pending;
    assign bus.state         = state;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: scenario tasks with a queue of expected redirects.
module tb_interrupt_arbiter;
    import interrupt_arbiter_pkg::*;

    localparam int EXP_W = 66;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interrupt_arbiter_if #(.NUM_SRC(4), .ID_W(2)) bus ();

    interrupt_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Expected redirect record: {cause_id, vector, return pc}.
    function automatic logic [EXP_W-1:0] mk_exp(input logic [1:0] id, input logic [31:0] epc);
        logic [31:0] v;
        case (id)
            2'd0:    v = 32'h14;
            2'd1:    v = 32'h18;
            2'd2:    v = 32'h1C;
            default: v = 32'h20;
        endcase
        return {id, v, epc};
    endfunction

    function automatic logic [EXP_W-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic logic [EXP_W-1:0] got_take();
        return {bus.cause_id, bus.pc_next_final, bus.epc_wr_data};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Waits up to max_c cycles for a TAKE; n = cycles waited, -1 on timeout.
    task automatic wait_take(input int max_c, output int n);
        n = -1;
        for (int c = 0; c <= max_c; c++) begin
            if (bus.epc_wr_en === 1'b1) begin
                n = c;
                return;
            end
            cyc();
            smp();
        end
    endtask

    task automatic leave_isr();
        cyc(); bus.isr_return = 1'b1; smp();
        cyc(); bus.isr_return = 1'b0; smp();
        cyc(); smp();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pc_next = 32'h55;
        repeat (3) cyc();
        cyc(); reset = 1'b0; smp();
        n_checks++; if (bus.state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", bus.state, ST_IDLE); else n_pass++;
        n_checks++; if (bus.pending !== 4'b0) $display("FAIL reset_pending got=%b exp=0000", bus.pending); else n_pass++;
        n_checks++; if (bus.in_isr !== 1'b0 || bus.epc_wr_en !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", bus.in_isr, bus.epc_wr_en); else n_pass++;
        n_checks++; if (bus.cause_id !== 2'd0) $display("FAIL reset_cause got=%0d exp=0", bus.cause_id); else n_pass++;
        n_checks++; if (bus.pc_next_final !== 32'h55) $display("FAIL reset_pc got=%h exp=00000055", bus.pc_next_final); else n_pass++;
    endtask

    task automatic test_single();
        logic [EXP_W-1:0] e;
        cyc(); bus.pc_next = 32'h100; bus.irq_in = 4'b0100; exp_q.push_back(mk_exp(2'd2, 32'h100)); smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        n_checks++; if (bus.pending !== 4'b0100) $display("FAIL single_pending got=%b exp=0100", bus.pending); else n_pass++;
        n_checks++; if (bus.epc_wr_en !== 1'b0) $display("FAIL single_early got=%b exp=0", bus.epc_wr_en); else n_pass++;
        cyc(); smp();
        n_checks++; if (bus.epc_wr_en !== 1'b1) $display("FAIL single_take_cycle got=%b exp=1", bus.epc_wr_en); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL single_take got=%h exp=%h", got_take(), e); else n_pass++;
        n_checks++; if (bus.in_isr !== 1'b1) $display("FAIL single_in_isr got=%b exp=1", bus.in_isr); else n_pass++;
        cyc(); smp();
        n_checks++; if (bus.pending !== 4'b0000) $display("FAIL single_clear got=%b exp=0000", bus.pending); else n_pass++;
        n_checks++; if (bus.state !== ST_ISR || bus.pc_next_final !== 32'h100) $display("FAIL single_isr got=%0d/%h exp=2/00000100", bus.state, bus.pc_next_final); else n_pass++;
        leave_isr();
    endtask

    task automatic test_two_src();
        logic [EXP_W-1:0] e;
        int n;
        cyc(); bus.pc_next = 32'h300; bus.irq_in = 4'b1010;
        exp_q.push_back(mk_exp(2'd1, 32'h300));
        exp_q.push_back(mk_exp(2'd3, 32'h304));
        smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        wait_take(4, n);
        n_checks++; if (n !== 1) $display("FAIL two_lat1 got=%0d exp=1", n); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL two_take1 got=%h exp=%h", got_take(), e); else n_pass++;
        cyc(); bus.pc_next = 32'h304; smp();
        cyc(); bus.isr_return = 1'b1; smp();
        cyc(); bus.isr_return = 1'b0; smp();
        n_checks++; if (bus.state !== ST_RETURN || bus.pc_next_final !== 32'h300) $display("FAIL two_return got=%0d/%h exp=3/00000300", bus.state, bus.pc_next_final); else n_pass++;
        cyc(); smp();
        n_checks++; if (bus.epc_wr_en !== 1'b0 || bus.state !== ST_IDLE) $display("FAIL two_idle got=%b/%0d exp=0/0", bus.epc_wr_en, bus.state); else n_pass++;
        wait_take(4, n);
        n_checks++; if (n !== 1) $display("FAIL two_lat2 got=%0d exp=1", n); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL two_take2 got=%h exp=%h", got_take(), e); else n_pass++;
        leave_isr();
    endtask

    task automatic test_mask();
        logic [EXP_W-1:0] e;
        int n;
        bit seen;
        cyc(); bus.pc_next = 32'h400; bus.mask_wr_en = 1'b1; bus.mask_wr_data = 4'b0010; smp();
        cyc(); bus.mask_wr_en = 1'b0; bus.irq_in = 4'b0010; exp_q.push_back(mk_exp(2'd1, 32'h400)); smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        seen = 1'b0;
        repeat (4) begin
            cyc(); smp();
            if (bus.epc_wr_en !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL mask_blocked got=%b exp=0", seen); else n_pass++;
        n_checks++; if (bus.pending !== 4'b0010) $display("FAIL mask_retained got=%b exp=0010", bus.pending); else n_pass++;
        cyc(); bus.mask_wr_en = 1'b1; bus.mask_wr_data = 4'b0000; smp();
        cyc(); bus.mask_wr_en = 1'b0; smp();
        n_checks++; if (bus.epc_wr_en !== 1'b0) $display("FAIL mask_early got=%b exp=0", bus.epc_wr_en); else n_pass++;
        wait_take(3, n);
        n_checks++; if (n !== 1) $display("FAIL mask_lat got=%0d exp=1", n); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL mask_take got=%h exp=%h", got_take(), e); else n_pass++;
        leave_isr();
    endtask

    task automatic test_return();
        logic [EXP_W-1:0] e;
        int n;
        cyc(); bus.pc_next = 32'h240; bus.irq_in = 4'b0001; exp_q.push_back(mk_exp(2'd0, 32'h240)); smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        wait_take(3, n);
        n_checks++; if (n !== 1) $display("FAIL ret_lat got=%0d exp=1", n); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL ret_take got=%h exp=%h", got_take(), e); else n_pass++;
        cyc(); bus.pc_next = 32'h500; smp();
        cyc(); bus.isr_return = 1'b1; smp();
        n_checks++; if (bus.pc_next_final !== 32'h500) $display("FAIL ret_isr_pass got=%h exp=00000500", bus.pc_next_final); else n_pass++;
        cyc(); bus.isr_return = 1'b0; smp();
        n_checks++; if (bus.state !== ST_RETURN || bus.pc_next_final !== 32'h240 || bus.in_isr !== 1'b1) $display("FAIL ret_restore got=%0d/%h/%b exp=3/00000240/1", bus.state, bus.pc_next_final, bus.in_isr); else n_pass++;
        cyc(); smp();
        n_checks++; if (bus.state !== ST_IDLE || bus.pc_next_final !== 32'h500 || bus.in_isr !== 1'b0) $display("FAIL ret_idle got=%0d/%h/%b exp=0/00000500/0", bus.state, bus.pc_next_final, bus.in_isr); else n_pass++;
    endtask

    task automatic test_isr_block();
        logic [EXP_W-1:0] e;
        int n;
        bit seen;
        cyc(); bus.pc_next = 32'h600; bus.irq_in = 4'b0100; exp_q.push_back(mk_exp(2'd2, 32'h600)); smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        wait_take(3, n);
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL blk_take1 got=%h exp=%h", got_take(), e); else n_pass++;
        cyc(); bus.irq_in = 4'b0001; exp_q.push_back(mk_exp(2'd0, 32'h600)); smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        seen = 1'b0;
        repeat (3) begin
            cyc(); smp();
            if (bus.epc_wr_en !== 1'b0 || bus.state !== ST_ISR) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL blk_nested got=%b exp=0", seen); else n_pass++;
        n_checks++; if (bus.pending !== 4'b0001) $display("FAIL blk_pending got=%b exp=0001", bus.pending); else n_pass++;
        cyc(); bus.isr_return = 1'b1; smp();
        cyc(); bus.isr_return = 1'b0; smp();
        seen = 1'b0;
        repeat (3) begin
            cyc(); bus.take_ready = 1'b0; smp();
            if (bus.epc_wr_en !== 1'b0 || bus.state !== ST_IDLE) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL blk_stall got=%b exp=0", seen); else n_pass++;
        cyc(); bus.take_ready = 1'b1; smp();
        wait_take(3, n);
        n_checks++; if (n !== 1) $display("FAIL blk_lat got=%0d exp=1", n); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL blk_take2 got=%h exp=%h", got_take(), e); else n_pass++;
        leave_isr();
    endtask

    task automatic test_enable();
        logic [EXP_W-1:0] e;
        int n;
        bit seen;
        cyc(); bus.pc_next = 32'h680; bus.irq_enable = 1'b0; bus.irq_in = 4'b1000; exp_q.push_back(mk_exp(2'd3, 32'h680)); smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        seen = 1'b0;
        repeat (3) begin
            cyc(); smp();
            if (bus.epc_wr_en !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || bus.pending !== 4'b1000) $display("FAIL en_blocked got=%b/%b exp=0/1000", seen, bus.pending); else n_pass++;
        cyc(); bus.irq_enable = 1'b1; smp();
        wait_take(3, n);
        n_checks++; if (n !== 1) $display("FAIL en_lat got=%0d exp=1", n); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL en_take got=%h exp=%h", got_take(), e); else n_pass++;
        cyc(); bus.irq_enable = 1'b0; bus.isr_return = 1'b1; smp();
        cyc(); bus.isr_return = 1'b0; smp();
        n_checks++; if (bus.state !== ST_RETURN || bus.pc_next_final !== 32'h680) $display("FAIL en_return got=%0d/%h exp=3/00000680", bus.state, bus.pc_next_final); else n_pass++;
        cyc(); bus.irq_enable = 1'b1; smp();
    endtask

    task automatic test_set_wins();
        logic [EXP_W-1:0] e;
        int n;
        cyc(); bus.pc_next = 32'h700; bus.irq_in = 4'b0100;
        exp_q.push_back(mk_exp(2'd2, 32'h700));
        exp_q.push_back(mk_exp(2'd2, 32'h700));
        smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        cyc(); bus.irq_in = 4'b0100; smp();
        n_checks++; if (bus.epc_wr_en !== 1'b1) $display("FAIL setw_take_cycle got=%b exp=1", bus.epc_wr_en); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL setw_take1 got=%h exp=%h", got_take(), e); else n_pass++;
        cyc(); bus.irq_in = 4'b0000; smp();
        n_checks++; if (bus.pending !== 4'b0100) $display("FAIL setw_pending got=%b exp=0100", bus.pending); else n_pass++;
        leave_isr();
        wait_take(3, n);
        n_checks++; if (n !== 1) $display("FAIL setw_lat got=%0d exp=1", n); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL setw_take2 got=%h exp=%h", got_take(), e); else n_pass++;
        leave_isr();
    endtask

    task automatic test_level();
        logic [EXP_W-1:0] e;
        int n;
        bit seen;
        cyc(); bus.pc_next = 32'h800; bus.irq_in = 4'b1000; exp_q.push_back(mk_exp(2'd3, 32'h800)); smp();
        wait_take(4, n);
        n_checks++; if (n !== 2) $display("FAIL level_lat got=%0d exp=2", n); else n_pass++;
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL level_take got=%h exp=%h", got_take(), e); else n_pass++;
        leave_isr();
        seen = 1'b0;
        repeat (5) begin
            cyc(); smp();
            if (bus.epc_wr_en !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || bus.pending !== 4'b0000) $display("FAIL level_once got=%b/%b exp=0/0000", seen, bus.pending); else n_pass++;
        cyc(); bus.irq_in = 4'b0000; smp();
    endtask

    task automatic test_reset_in_isr();
        logic [EXP_W-1:0] e;
        int n;
        bit seen;
        cyc(); bus.pc_next = 32'h900; bus.irq_in = 4'b0010; exp_q.push_back(mk_exp(2'd1, 32'h900)); smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        wait_take(3, n);
        e = pop_exp();
        n_checks++; if (got_take() !== e) $display("FAIL rst_take got=%h exp=%h", got_take(), e); else n_pass++;
        cyc(); bus.irq_in = 4'b1000; exp_q.push_back(mk_exp(2'd3, 32'h900)); smp();
        cyc(); bus.irq_in = 4'b0000; smp();
        n_checks++; if (bus.pending !== 4'b1000) $display("FAIL rst_pre_pending got=%b exp=1000", bus.pending); else n_pass++;
        cyc(); reset = 1'b1; smp();
        cyc(); reset = 1'b0; exp_q.delete(); smp();
        n_checks++; if (bus.state !== ST_IDLE || bus.in_isr !== 1'b0) $display("FAIL rst_idle got=%0d/%b exp=0/0", bus.state, bus.in_isr); else n_pass++;
        n_checks++; if (bus.pending !== 4'b0000) $display("FAIL rst_pending got=%b exp=0000", bus.pending); else n_pass++;
        n_checks++; if (bus.pc_next_final !== 32'h900) $display("FAIL rst_pc got=%h exp=00000900", bus.pc_next_final); else n_pass++;
        cyc(); bus.pc_next = 32'hA00; bus.isr_return = 1'b1; smp();
        cyc(); bus.isr_return = 1'b0; smp();
        seen = 1'b0;
        repeat (3) begin
            if (bus.state !== ST_IDLE || bus.pc_next_final !== 32'hA00 || bus.epc_wr_en !== 1'b0) seen = 1'b1;
            cyc(); smp();
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_ret_ignored got=%b exp=0", seen); else n_pass++;
    endtask

    initial begin
        reset            = 1'b1;
        bus.irq_in       = '0;
        bus.irq_enable   = 1'b1;
        bus.mask_wr_en   = 1'b0;
        bus.mask_wr_data = '0;
        bus.take_ready   = 1'b1;
        bus.isr_return   = 1'b0;
        bus.pc_next      = '0;

        test_reset();
        test_single();
        test_two_src();
        test_mask();
        test_return();
        test_isr_block();
        test_enable();
        test_set_wins();
        test_level();
        test_reset_in_isr();

        n_checks++; if (exp_q.size() !== 0) $display("FAIL leftover_exp got=%0d exp=0", exp_q.size()); else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
